// File: rtl/maf_filter_pipe.sv
// Running-sum moving-average filter: circular sample window, full-precision
// accumulator, signed/unsigned mode, optional rounding, two-stage pipeline.
module maf_filter_pipe #(
  parameter int DATA_W     = 16,
  parameter int LOG2_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              sgn,
  input  logic              round_en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              out_full
);

  localparam int DEPTH  = 1 << LOG2_DEPTH;
  localparam int ACC_W  = DATA_W + LOG2_DEPTH;
  localparam int PTR_W  = (LOG2_DEPTH > 0) ? LOG2_DEPTH : 1;
  localparam int FILL_W = LOG2_DEPTH + 1;

  localparam logic [ACC_W-1:0]  RND      = ACC_W'(DEPTH / 2);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

  logic [DATA_W-1:0] buf_reg [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [FILL_W-1:0] fill_reg, fill_next;
  logic [ACC_W-1:0]  acc_reg, acc_next;
  logic              v1_reg;

  logic              accept;
  logic [DATA_W-1:0] old_sample;
  logic [ACC_W-1:0]  rnd_sum;
  logic [ACC_W-1:0]  avg_full;
  logic signed [ACC_W-1:0] rnd_sum_s;

  function automatic logic [ACC_W-1:0] ext(input logic [DATA_W-1:0] x, input logic s);
    logic signed [DATA_W-1:0] xs;
    logic [ACC_W-1:0]         r;
    xs = x;
    r  = ACC_W'(x);
    if (s) r = ACC_W'(xs);
    return r;
  endfunction

  always_comb begin
    accept      = in_valid & ~clear;
    old_sample  = buf_reg[wr_ptr_reg];
    wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
    fill_next   = (fill_reg == FILL_MAX) ? fill_reg : fill_reg + 1'b1;
    acc_next    = acc_reg + ext(data_in, sgn) - ext(old_sample, sgn);

    // Headroom in acc guarantees the rounding offset cannot carry out.
    rnd_sum   = acc_reg + (round_en ? RND : '0);
    rnd_sum_s = rnd_sum;
    if (sgn) avg_full = rnd_sum_s >>> LOG2_DEPTH;
    else     avg_full = rnd_sum >> LOG2_DEPTH;
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_buf
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          buf_reg[gi] <= '0;
        end else if (clear) begin
          buf_reg[gi] <= '0;
        end else if (accept && (wr_ptr_reg == PTR_W'(gi))) begin
          buf_reg[gi] <= data_in;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      fill_reg   <= '0;
      acc_reg    <= '0;
      v1_reg     <= 1'b0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      fill_reg   <= '0;
      acc_reg    <= '0;
      v1_reg     <= 1'b0;
    end else if (accept) begin
      wr_ptr_reg <= wr_ptr_next;
      fill_reg   <= fill_next;
      acc_reg    <= acc_next;
      v1_reg     <= 1'b1;
    end else begin
      v1_reg     <= 1'b0;
    end
  end

  // An in-flight result wins over clear so it emits with its own out_full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      out_full  <= 1'b0;
    end else begin
      out_valid <= v1_reg;
      if (v1_reg) begin
        data_out <= avg_full[DATA_W-1:0];
        out_full <= (fill_reg == FILL_MAX);
      end else if (clear) begin
        out_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_maf_filter_pipe.sv
// Self-checking bench for maf_filter_pipe (DATA_W=16, DEPTH=4): directed vector
// table plus randomized traffic checked against a queue-based window model.
module tb_maf_filter_pipe;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        sgn = 1'b0;
  logic        round_en = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] data_in = '0;
  logic        out_valid;
  logic [15:0] data_out;
  logic        out_full;

  always #5 clk = ~clk;

  maf_filter_pipe #(.DATA_W(16), .LOG2_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .clear(clear), .sgn(sgn), .round_en(round_en),
    .in_valid(in_valid), .data_in(data_in),
    .out_valid(out_valid), .data_out(data_out), .out_full(out_full)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, got, want);
  endtask

  // Directed vectors: one row per clock; expected outputs are those seen after
  // that row's edge (i.e. stage 2 of the previous row's sample).
  typedef struct {
    logic v, c, s, r;
    logic [15:0] d;
    logic eov;
    logic [15:0] ed;
    logic ef;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic v, c, s, r, input logic [15:0] d,
                              input logic eov, input logic [15:0] ed, input logic ef);
    vec_t e;
    e.v = v; e.c = c; e.s = s; e.r = r; e.d = d;
    e.eov = eov; e.ed = ed; e.ef = ef;
    tbl.push_back(e);
  endfunction

  // Reference model: the window is a queue of the last DEPTH accepted values.
  longint      win[$];
  int          fill_m;
  bit          pv;
  longint      psum;
  bit          pfull;
  logic [15:0] hd;
  bit          hf;

  function automatic longint interp(input logic [15:0] d, input bit s);
    if (s) return longint'($signed(d));
    return longint'(d);
  endfunction

  function automatic logic [15:0] avg_of(input longint sum, input bit r);
    longint t, q;
    t = sum + (r ? DEPTH / 2 : 0);
    q = t / DEPTH;
    if (t < 0 && q * DEPTH != t) q = q - 1;
    return q[15:0];
  endfunction

  task automatic model_reset();
    win.delete();
    for (int i = 0; i < DEPTH; i++) win.push_back(0);
    fill_m = 0; pv = 0; psum = 0; pfull = 0; hd = '0; hf = 0;
  endtask

  task automatic cycle(input bit v, input bit c, input bit s, input bit r,
                       input logic [15:0] d, input string tag);
    bit eov;
    in_valid = v; clear = c; sgn = s; round_en = r; data_in = d;
    eov = pv;
    if (pv) begin
      hd = avg_of(psum, r);
      hf = pfull;
    end else if (c) begin
      hf = 0;
    end
    if (c) begin
      win.delete();
      for (int i = 0; i < DEPTH; i++) win.push_back(0);
      fill_m = 0;
      pv = 0;
    end else if (v) begin
      win.push_back(interp(d, s));
      void'(win.pop_front());
      if (fill_m < DEPTH) fill_m++;
      psum = 0;
      foreach (win[i]) psum += win[i];
      pfull = (fill_m == DEPTH);
      pv = 1;
    end else begin
      pv = 0;
    end
    @(posedge clk); @(negedge clk);
    check({tag, ".valid"}, 16'(out_valid), 16'(eov));
    check({tag, ".data"},  data_out, hd);
    check({tag, ".full"},  16'(out_full), 16'(hf));
  endtask

  function automatic logic [15:0] pick_data();
    int k;
    k = $urandom_range(0, 9);
    case (k)
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic random_run(input int n, inout bit s_cur);
    for (int i = 0; i < n; i++) begin
      int k;
      k = $urandom_range(0, 99);
      if (k < 4) begin
        cycle(bit'($urandom_range(0, 1)), 1, s_cur, bit'($urandom_range(0, 1)), pick_data(), "rnd_clr");
        s_cur = bit'($urandom_range(0, 1));
        cycle(0, 1, s_cur, 0, pick_data(), "rnd_clr2");
      end else begin
        cycle(k < 80, 0, s_cur, bit'($urandom_range(0, 1)), pick_data(), "rnd");
      end
    end
  endtask

  initial begin
    bit s_cur;

    // Reset held: outputs stay zero whatever the inputs do.
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = bit'($urandom_range(0, 1));
      clear    = bit'($urandom_range(0, 1));
      round_en = bit'($urandom_range(0, 1));
      data_in  = 16'($urandom);
      @(posedge clk); #1;
      check("rst_hold.valid", 16'(out_valid), 16'h0);
      check("rst_hold.data",  data_out, 16'h0);
      check("rst_hold.full",  16'(out_full), 16'h0);
    end
    @(negedge clk);
    in_valid = 0; clear = 0; sgn = 0; round_en = 0; data_in = '0;
    rst = 1'b1;
    @(negedge clk);

    // Ramp, signed, rounding, no-wrap, gaps and clear.
    add(1,0,0,0,16'd4,    0,16'h0000,0);
    add(1,0,0,0,16'd8,    1,16'd1,0);
    add(1,0,0,0,16'd12,   1,16'd3,0);
    add(1,0,0,0,16'd16,   1,16'd6,0);
    add(1,0,0,0,16'd20,   1,16'd10,1);
    add(0,0,0,0,16'd0,    1,16'd14,1);
    add(0,0,0,0,16'd0,    0,16'd14,1);
    add(0,1,1,0,16'd0,    0,16'd14,0);
    add(1,0,1,0,16'hFFFC, 0,16'd14,0);
    add(1,0,1,0,16'hFFFC, 1,16'hFFFF,0);
    add(1,0,1,0,16'hFFFC, 1,16'hFFFE,0);
    add(1,0,1,0,16'hFFFC, 1,16'hFFFD,0);
    add(1,0,1,0,16'h0004, 1,16'hFFFC,1);
    add(0,0,1,0,16'd0,    1,16'hFFFE,1);
    add(0,1,0,1,16'd0,    0,16'hFFFE,0);
    add(1,0,0,1,16'd1,    0,16'hFFFE,0);
    add(1,0,0,1,16'd1,    1,16'd0,0);
    add(0,0,0,1,16'd0,    1,16'd1,0);
    add(0,1,0,0,16'd0,    0,16'd1,0);
    add(1,0,0,0,16'd1,    0,16'd1,0);
    add(1,0,0,0,16'd1,    1,16'd0,0);
    add(0,0,0,0,16'd0,    1,16'd0,0);
    add(0,1,0,0,16'd0,    0,16'd0,0);
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: add(1,0,0,0,16'hFFFF, 0,16'h0000,0);
        1: add(1,0,0,0,16'hFFFF, 1,16'h3FFF,0);
        2: add(1,0,0,0,16'hFFFF, 1,16'h7FFF,0);
        3: add(1,0,0,0,16'hFFFF, 1,16'hBFFF,0);
        4: add(1,0,0,0,16'hFFFF, 1,16'hFFFF,1);
        default: add(1,0,0,0,16'hFFFF, 1,16'hFFFF,1);
      endcase
    end
    add(0,0,0,0,16'd0,    1,16'hFFFF,1);
    add(0,1,0,0,16'd0,    0,16'hFFFF,0);
    add(1,0,0,0,16'd8,    0,16'hFFFF,0);
    add(0,0,0,0,16'd0,    1,16'd2,0);
    add(1,0,0,0,16'd8,    0,16'd2,0);
    add(0,0,0,0,16'd0,    1,16'd4,0);
    add(0,0,0,0,16'd0,    0,16'd4,0);
    add(1,1,0,0,16'd100,  0,16'd4,0);
    add(0,0,0,0,16'd0,    0,16'd4,0);
    add(1,0,0,0,16'd8,    0,16'd4,0);
    add(0,0,0,0,16'd0,    1,16'd2,0);

    for (int i = 0; i < tbl.size(); i++) begin
      in_valid = tbl[i].v; clear = tbl[i].c; sgn = tbl[i].s;
      round_en = tbl[i].r; data_in = tbl[i].d;
      @(posedge clk); @(negedge clk);
      check($sformatf("tbl[%0d].valid", i), 16'(out_valid), 16'(tbl[i].eov));
      check($sformatf("tbl[%0d].data", i),  data_out, tbl[i].ed);
      check($sformatf("tbl[%0d].full", i),  16'(out_full), 16'(tbl[i].ef));
    end

    // Restart from reset for the model-checked random phase.
    in_valid = 0; clear = 0; sgn = 0; round_en = 0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    s_cur = 0;
    random_run(150, s_cur);

    // Mid-stream async reset pulse: outputs drop before any clock edge.
    cycle(1, 0, s_cur, 0, 16'h1234, "pre_rst");
    cycle(1, 0, s_cur, 0, 16'h4321, "pre_rst");
    #2 rst = 1'b0;
    #1;
    check("rst_async.valid", 16'(out_valid), 16'h0);
    check("rst_async.data",  data_out, 16'h0);
    check("rst_async.full",  16'(out_full), 16'h0);
    in_valid = 0; clear = 0;
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    model_reset();
    s_cur = 0;
    random_run(250, s_cur);

    // Clear while a full-window result is still in flight.
    cycle(0, 1, 0, 0, 16'd0, "fl_clr");
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 16'd4, "fl_fill");
    cycle(0, 1, 0, 0, 16'd0, "fl_inflight");
    cycle(0, 0, 0, 0, 16'd0, "fl_hold");
    cycle(1, 0, 0, 0, 16'd8, "fl_next");
    cycle(0, 0, 0, 0, 16'd0, "fl_after");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/maf_filter_pipe.md
# maf_filter_pipe

Parametrised running-sum moving-average filter, the successor to the fixed 16-bit / 4-tap MAF. It adds configurable width and window depth, a full-precision accumulator that cannot wrap, signed or unsigned mode, optional rounding, a valid handshake with gap tolerance, and a synchronous window clear. It sits in the sonar receive datapath between the sample source and the downstream detectors, and processes one sample per clock.

## Interface

Parameters:
- DATA_W, 16 — sample and result width in bits.
- LOG2_DEPTH, 2 — window depth is DEPTH = 2^LOG2_DEPTH. Legal range is 0..6.

Ports:
- clk  in  1  — system clock; all logic is on its rising edge.
- rst  in  1  — reset, asynchronous, active-low. It clears every register.
- clear  in  1  — synchronous window flush, active high.
- sgn  in  1  — 1 = two's-complement samples, 0 = unsigned. Quasi-static: change it only while clear=1 or rst=0.
- round_en  in  1  — 1 = round half up before the divide, 0 = truncate (floor).
- in_valid  in  1  — data_in is valid this cycle. The block is always ready and has no backpressure.
- data_in  in  DATA_W  — input sample.
- out_valid  out  1  — single-cycle pulse, one per accepted sample.
- data_out  out  DATA_W  — window average. Held between pulses.
- out_full  out  1  — qualifies data_out: 1 once DEPTH samples have entered since the last reset or clear.

## Operation

Storage:
- Circular buffer buf[0..DEPTH-1] of DATA_W bits, all zero after reset or clear.
- wr_ptr, LOG2_DEPTH bits, wraps from DEPTH-1 to 0.
- fill counter, saturating at DEPTH.
- acc, ACC_W = DATA_W + LOG2_DEPTH bits.

Stage 1, on an edge where in_valid=1 and clear=0:
- Read old = buf[wr_ptr], write buf[wr_ptr] <= data_in, advance wr_ptr.
- acc <= acc + ext(data_in) - ext(old). ext() sign-extends when sgn=1 and zero-extends when sgn=0.
- fill <= min(fill+1, DEPTH).
- Set the stage-1 valid flag v1.

Stage 2, on an edge with v1=1:
- data_out <= (acc + R) >>> LOG2_DEPTH, truncated to DATA_W bits.
- R = 2^(LOG2_DEPTH-1) when round_en=1 and LOG2_DEPTH>0, else 0.
- The shift is arithmetic when sgn=1 and logical when sgn=0.
- out_valid <= 1. out_full <= (fill == DEPTH) as of that same edge.

Width rules:
- acc spans DEPTH times the full input range, so it never overflows.
- The average lies within the input range, so truncating the shifted value to DATA_W bits loses nothing, rounding included.
- A negative result with sgn=1 and truncation rounds toward minus infinity.

Warm-up:
- The buffer starts at zero, so the first DEPTH-1 outputs are the zero-padded average (sum / DEPTH). out_full=0 marks them.

in_valid gaps:
- When in_valid=0, stage 1 holds its state, v1 clears, and out_valid is 0 on the next cycle.
- data_out and out_full hold their values.

clear:
- On the edge it is sampled, buf, acc, wr_ptr, fill, v1 and out_full all go to zero.
- clear beats a simultaneous in_valid; that sample is discarded.
- A stage-2 result already in flight when clear is sampled still emits, with its original value and its original out_full.
- data_out keeps its last value.

rst:
- Asserted at any time, it immediately forces every register to zero: data_out=0, out_valid=0, out_full=0.
- Processing restarts cleanly after the first clk edge with rst=1.

## Timing

- Latency is 2 cycles: a sample accepted at edge k produces out_valid=1 and its data_out during the cycle after edge k+1.
- Throughput is 1 sample per clock; back-to-back in_valid gives back-to-back out_valid.
- The average includes the current sample, i.e. the last DEPTH accepted samples.
- The critical path is acc add/subtract (ACC_W bits) in stage 1, then round-and-shift in stage 2.
- The combinational read of buf[wr_ptr] is a DEPTH:1 mux.
- Reset values of all outputs are 0.

## Test plan

All scenarios use DATA_W=16, LOG2_DEPTH=2 (DEPTH=4).

1. Reset: hold rst=0, drive random inputs -> data_out=0, out_valid=0, out_full=0 throughout. Pulse rst=0 for one cycle mid-stream -> all outputs 0 immediately, next window starts from zero.
2. Unsigned ramp, sgn=0, round_en=0, inputs 4,8,12,16,20 back-to-back -> data_out 1,3,6,10,14 at 2-cycle latency. out_full goes 1 with the 10 output.
3. Signed: sgn=1, four samples of 0xFFFC (-4) -> data_out 0xFFFF, 0xFFFE, 0xFFFD, 0xFFFC. Then a single 0x0004 -> 0xFFFE (sum -8, average -2).
4. Rounding: inputs 1,1 with round_en=1 -> data_out 0, 1. The same inputs with round_en=0 -> 0, 0.
5. Saturation-free: sgn=0, six samples of 0xFFFF -> final data_out=0xFFFF, with no wrap.
6. Gaps and clear:
   - Inputs 8 (gap) 8 -> exactly 2 out_valid pulses, with data_out held during the gap.
   - Assert clear together with in_valid carrying 100 -> no out_valid for 100.
   - Next input 8 -> data_out=2, out_full=0.
